// File: rtl/seven_segment_receiver_if.sv
// Bus bundle between a multiplexed two-digit seven-segment driver and its loopback receiver.
// The driver side owns enable/segments/digit/invert; the receiver side owns the decoded results.
interface seven_segment_receiver_if;
    // Handshake: valid, pattern_err and sync_err are single-cycle strobes with no ready and
    // no backpressure. ten_count/unit_count are only meaningful on, and held after, a valid strobe.
    logic       enable;
    logic [6:0] segments;
    logic       digit;
    logic       invert;

    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       valid;
    logic       locked;
    logic       pattern_err;
    logic       sync_err;
    logic [1:0] rx_state;

    modport master (
        output enable, segments, digit, invert,
        input  ten_count, unit_count, valid, locked, pattern_err, sync_err, rx_state
    );

    modport slave (
        input  enable, segments, digit, invert,
        output ten_count, unit_count, valid, locked, pattern_err, sync_err, rx_state
    );
endinterface

// File: rtl/seven_segment_receiver.sv
// Locks onto the tens/units alternation of a two-digit seven-segment bus, decodes each frame
// and republishes the BCD pair once it has been stable for STABLE_FRAMES consecutive frames.
module seven_segment_receiver #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    seven_segment_receiver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SYNC     = 2'd1,
        CAP_UNIT = 2'd2,
        CAP_TEN  = 2'd3
    } state_t;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_FRAMES);

    state_t     state_q, state_d;
    logic       prev_digit_q;
    logic [3:0] tens_code_q, tens_code_d;
    logic       tens_legal_q, tens_legal_d;
    logic [3:0] match_cnt_q, match_cnt_d;
    logic [7:0] last_frame_q, last_frame_d;
    logic       first_frame_q, first_frame_d;
    logic [3:0] ten_count_q, ten_count_d;
    logic [3:0] unit_count_q, unit_count_d;
    logic       valid_q, valid_d;
    logic       pattern_err_q, pattern_err_d;
    logic       sync_err_q, sync_err_d;

    logic [6:0] pat;
    logic [3:0] dec_code;
    logic       dec_legal;
    logic [7:0] frame;

    assign pat = bus.segments ^ {7{bus.invert}};

    always_comb begin
        dec_legal = 1'b1;
        dec_code  = 4'h0;
        case (pat)
            7'b0111111: dec_code = 4'd0;
            7'b0000110: dec_code = 4'd1;
            7'b1011011: dec_code = 4'd2;
            7'b1001111: dec_code = 4'd3;
            7'b1100110: dec_code = 4'd4;
            7'b1101101: dec_code = 4'd5;
            7'b1111100: dec_code = 4'd6;
            7'b0000111: dec_code = 4'd7;
            7'b1111111: dec_code = 4'd8;
            7'b1100111: dec_code = 4'd9;
            7'b0000000: dec_code = 4'hF;
            default: begin
                dec_code  = 4'h0;
                dec_legal = 1'b0;
            end
        endcase
    end

    assign frame = {tens_code_q, dec_code};

    always_comb begin
        state_d       = state_q;
        tens_code_d   = tens_code_q;
        tens_legal_d  = tens_legal_q;
        match_cnt_d   = match_cnt_q;
        last_frame_d  = last_frame_q;
        first_frame_d = first_frame_q;
        ten_count_d   = ten_count_q;
        unit_count_d  = unit_count_q;
        valid_d       = 1'b0;
        pattern_err_d = 1'b0;
        sync_err_d    = 1'b0;

        if (!bus.enable) begin
            state_d       = IDLE;
            match_cnt_d   = 4'd0;
            last_frame_d  = 8'd0;
            first_frame_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = SYNC;

                SYNC: begin
                    // Only a 0->1 transition on digit marks the start of a tens phase.
                    if (bus.digit && !prev_digit_q) begin
                        tens_code_d   = dec_code;
                        tens_legal_d  = dec_legal;
                        first_frame_d = 1'b1;
                        state_d       = CAP_UNIT;
                    end
                end

                CAP_UNIT: begin
                    if (bus.digit == prev_digit_q) begin
                        sync_err_d  = 1'b1;
                        match_cnt_d = 4'd0;
                        state_d     = SYNC;
                    end else begin
                        state_d = CAP_TEN;
                        if (!(tens_legal_q && dec_legal)) begin
                            pattern_err_d = 1'b1;
                            match_cnt_d   = 4'd0;
                        end else if (!first_frame_q && frame == last_frame_q) begin
                            // Saturated hold never republishes; only the crossing does.
                            if (match_cnt_q < STABLE_CNT) begin
                                match_cnt_d = match_cnt_q + 4'd1;
                                if (match_cnt_q + 4'd1 == STABLE_CNT) begin
                                    ten_count_d  = tens_code_q;
                                    unit_count_d = dec_code;
                                    valid_d      = 1'b1;
                                end
                            end
                        end else begin
                            match_cnt_d   = 4'd1;
                            last_frame_d  = frame;
                            first_frame_d = 1'b0;
                            if (STABLE_CNT == 4'd1) begin
                                ten_count_d  = tens_code_q;
                                unit_count_d = dec_code;
                                valid_d      = 1'b1;
                            end
                        end
                    end
                end

                CAP_TEN: begin
                    if (bus.digit == prev_digit_q) begin
                        sync_err_d  = 1'b1;
                        match_cnt_d = 4'd0;
                        state_d     = SYNC;
                    end else begin
                        tens_code_d  = dec_code;
                        tens_legal_d = dec_legal;
                        state_d      = CAP_UNIT;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            prev_digit_q  <= 1'b0;
            tens_code_q   <= 4'd0;
            tens_legal_q  <= 1'b0;
            match_cnt_q   <= 4'd0;
            last_frame_q  <= 8'd0;
            first_frame_q <= 1'b1;
            ten_count_q   <= 4'd0;
            unit_count_q  <= 4'd0;
            valid_q       <= 1'b0;
            pattern_err_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_digit_q  <= bus.digit;
            tens_code_q   <= tens_code_d;
            tens_legal_q  <= tens_legal_d;
            match_cnt_q   <= match_cnt_d;
            last_frame_q  <= last_frame_d;
            first_frame_q <= first_frame_d;
            ten_count_q   <= ten_count_d;
            unit_count_q  <= unit_count_d;
            valid_q       <= valid_d;
            pattern_err_q <= pattern_err_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.ten_count   = ten_count_q;
    assign bus.unit_count  = unit_count_q;
    assign bus.valid       = valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.locked      = (state_q == CAP_UNIT) || (state_q == CAP_TEN);
    assign bus.rx_state    = state_q;

endmodule

// File: tb/tb_seven_segment_receiver.sv
// Directed bench for seven_segment_receiver: each task drives one scenario and checks inline.
module tb_seven_segment_receiver;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    int   valid_cnt;
    int   perr_cnt;
    int   serr_cnt;

    localparam logic [6:0] BAD_PAT = 7'b1010101;

    seven_segment_receiver_if bus ();

    seven_segment_receiver #(.STABLE_FRAMES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b0111111;
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            6:       return 7'b1111100;
            7:       return 7'b0000111;
            8:       return 7'b1111111;
            9:       return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic clear_counts();
        valid_cnt = 0;
        perr_cnt  = 0;
        serr_cnt  = 0;
    endtask

    // One bus sample: drive, let the edge take it, then observe 1 time unit later.
    task automatic step(input logic d, input logic [6:0] p);
        bus.digit    = d;
        bus.segments = p ^ {7{bus.invert}};
        @(posedge clk);
        #1;
        if (bus.valid === 1'b1) valid_cnt++;
        if (bus.pattern_err === 1'b1) perr_cnt++;
        if (bus.sync_err === 1'b1) serr_cnt++;
    endtask

    task automatic send_frame(input int t, input int u);
        step(1'b1, seg_of(t));
        step(1'b0, seg_of(u));
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.invert   = 1'b0;
        bus.digit    = 1'b0;
        bus.segments = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.ten_count !== 4'd0) begin n_bad++; $display("FAIL rst_ten got=%0h exp=0", bus.ten_count); end
        n_cmp++; if (bus.unit_count !== 4'd0) begin n_bad++; $display("FAIL rst_unit got=%0h exp=0", bus.unit_count); end
        n_cmp++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", bus.valid); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL rst_locked got=%b exp=0", bus.locked); end
        n_cmp++; if (bus.pattern_err !== 1'b0) begin n_bad++; $display("FAIL rst_perr got=%b exp=0", bus.pattern_err); end
        n_cmp++; if (bus.sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_serr got=%b exp=0", bus.sync_err); end
        n_cmp++; if (bus.rx_state !== 2'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", bus.rx_state); end
        reset_n = 1'b1;
    endtask

    task automatic test_clean_42();
        clear_counts();
        bus.enable = 1'b1;
        step(1'b0, 7'd0);
        step(1'b0, 7'd0);
        step(1'b1, seg_of(4));
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL lock_rise got=%b exp=1", bus.locked); end
        step(1'b0, seg_of(2));
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL clean_first_frame valid=%0d exp=0", valid_cnt); end
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL clean_valid got=%0d exp=1", valid_cnt); end
        n_cmp++; if (bus.ten_count !== 4'd4) begin n_bad++; $display("FAIL clean_ten got=%0h exp=4", bus.ten_count); end
        n_cmp++; if (bus.unit_count !== 4'd2) begin n_bad++; $display("FAIL clean_unit got=%0h exp=2", bus.unit_count); end
        for (int i = 0; i < 3; i++) begin
            send_frame(4, 2);
            n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL clean_locked frame=%0d got=%b exp=1", i, bus.locked); end
        end
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL clean_no_repub got=%0d exp=1", valid_cnt); end
    endtask

    task automatic test_pattern_err();
        clear_counts();
        step(1'b1, seg_of(4));
        step(1'b0, BAD_PAT);
        n_cmp++; if (perr_cnt !== 1) begin n_bad++; $display("FAIL perr_pulse got=%0d exp=1", perr_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h42) begin n_bad++; $display("FAIL perr_hold got=%h exp=42", {bus.ten_count, bus.unit_count}); end
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL perr_early_valid got=%0d exp=0", valid_cnt); end
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL perr_repub got=%0d exp=1", valid_cnt); end
        n_cmp++; if (perr_cnt !== 1) begin n_bad++; $display("FAIL perr_once got=%0d exp=1", perr_cnt); end
    endtask

    task automatic test_glitch_43();
        clear_counts();
        send_frame(4, 3);
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL glitch_43_valid got=%0d exp=0", valid_cnt); end
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL glitch_resume_valid got=%0d exp=0", valid_cnt); end
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL glitch_repub got=%0d exp=1", valid_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h42) begin n_bad++; $display("FAIL glitch_value got=%h exp=42", {bus.ten_count, bus.unit_count}); end
    endtask

    // Stall on a sample that also carries an illegal pattern: only sync_err may fire.
    task automatic test_sync_err();
        clear_counts();
        step(1'b1, seg_of(4));
        step(1'b1, BAD_PAT);
        n_cmp++; if (serr_cnt !== 1) begin n_bad++; $display("FAIL serr_pulse got=%0d exp=1", serr_cnt); end
        n_cmp++; if (perr_cnt !== 0) begin n_bad++; $display("FAIL serr_no_perr got=%0d exp=0", perr_cnt); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL serr_unlock got=%b exp=0", bus.locked); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h42) begin n_bad++; $display("FAIL serr_hold got=%h exp=42", {bus.ten_count, bus.unit_count}); end
        step(1'b0, seg_of(2));
        send_frame(4, 2);
        send_frame(4, 2);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL serr_relock_valid got=%0d exp=1", valid_cnt); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL serr_relocked got=%b exp=1", bus.locked); end
    endtask

    task automatic test_invert_90();
        clear_counts();
        bus.invert = 1'b1;
        send_frame(9, 0);
        send_frame(9, 0);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL inv_valid got=%0d exp=1", valid_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h90) begin n_bad++; $display("FAIL inv_value got=%h exp=90", {bus.ten_count, bus.unit_count}); end
        n_cmp++; if (perr_cnt !== 0) begin n_bad++; $display("FAIL inv_perr got=%0d exp=0", perr_cnt); end
        bus.invert = 1'b0;
    endtask

    task automatic test_blank_7();
        clear_counts();
        send_frame(15, 7);
        send_frame(15, 7);
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL blank_valid got=%0d exp=1", valid_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'hF7) begin n_bad++; $display("FAIL blank_value got=%h exp=f7", {bus.ten_count, bus.unit_count}); end
    endtask

    task automatic test_enable();
        clear_counts();
        bus.enable = 1'b0;
        send_frame(5, 5);
        send_frame(5, 5);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL en_low_locked got=%b exp=0", bus.locked); end
        n_cmp++; if (bus.rx_state !== 2'd0) begin n_bad++; $display("FAIL en_low_state got=%0d exp=0", bus.rx_state); end
        n_cmp++; if (valid_cnt + perr_cnt + serr_cnt !== 0) begin n_bad++; $display("FAIL en_low_pulses got=%0d exp=0", valid_cnt + perr_cnt + serr_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'hF7) begin n_bad++; $display("FAIL en_low_hold got=%h exp=f7", {bus.ten_count, bus.unit_count}); end
        bus.enable = 1'b1;
        for (int i = 0; i < 6; i++) step((i % 2) == 0, seg_of(5));
        n_cmp++; if (valid_cnt !== 1) begin n_bad++; $display("FAIL en_latency got=%0d exp=1", valid_cnt); end
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h55) begin n_bad++; $display("FAIL en_value got=%h exp=55", {bus.ten_count, bus.unit_count}); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, seg_of(5));
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({bus.ten_count, bus.unit_count} !== 8'h00) begin n_bad++; $display("FAIL midrst_value got=%h exp=00", {bus.ten_count, bus.unit_count}); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL midrst_locked got=%b exp=0", bus.locked); end
        n_cmp++; if (bus.rx_state !== 2'd0) begin n_bad++; $display("FAIL midrst_state got=%0d exp=0", bus.rx_state); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clear_counts();
        test_reset();
        test_clean_42();
        test_pattern_err();
        test_glitch_43();
        test_sync_err();
        test_invert_90();
        test_blank_7();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_receiver.md
# seven_segment_receiver

Samples the multiplexed two-digit seven-segment bus (`segments`, `digit`) produced by the frequency counter's display driver and reconstructs the tens and units BCD values. It locks onto the digit alternation, decodes each phase's pattern, and publishes a value only after it has been seen unchanged for a programmable number of frames. It serves as the on-chip loopback checker for the display path and feeds self-test and readback logic. It runs in the same clock domain as the driver.

## Interface
- `STABLE_FRAMES`, default 2: number of consecutive identical legal frames required before publishing; legal range 1–15.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  receiver enable; low forces IDLE.
- `segments`  in  7  segment bus; bit 6 = segment 7 … bit 0 = segment 1.
- `digit`  in  1  driver phase line.
- `invert`  in  1  bus polarity; 1 means segments are active-low.
- `ten_count`  out  4  published tens value.
- `unit_count`  out  4  published units value.
- `valid`  out  1  one-cycle pulse when the outputs are (re)published.
- `locked`  out  1  high while tracking digit alternation.
- `pattern_err`  out  1  one-cycle pulse when a frame contains an illegal pattern.
- `sync_err`  out  1  one-cycle pulse when alternation is lost while locked.

## Operation
- Normalisation:
  - pat = segments XOR {7{invert}}.
  - Decode pat to a 4-bit code:
    - 0111111→0, 0000110→1, 1011011→2, 1001111→3, 1100110→4
    - 1101101→5, 1111100→6, 0000111→7, 1111111→8, 1100111→9
    - 0000000→4'hF (blank, legal)
  - Any other pattern is illegal.
- Phase pairing: the driver registers segments one cycle behind `digit`.
  - A sample with `digit`=1 carries the tens digit.
  - A sample with `digit`=0 carries the units digit.
  - A frame is one tens sample followed by one units sample.
- State machine. `prev_digit` register holds the `digit` value of the previous sample.
  - IDLE: entered while `enable`=0. Go to SYNC when `enable`=1.
  - SYNC: wait for a sample with `digit`=1 and `prev_digit`=0. On that sample, capture tens and go to CAP_UNIT.
  - CAP_UNIT: the sample must have `digit`=0. Capture units, evaluate the frame, then go to CAP_TEN.
  - CAP_TEN: the sample must have `digit`=1. Capture tens, then go to CAP_UNIT.
  - In CAP_TEN or CAP_UNIT, a sample whose `digit` equals `prev_digit`:
    - pulse `sync_err`;
    - clear the match counter;
    - discard the partial frame;
    - go to SYNC.
- `locked` = 1 in CAP_TEN and CAP_UNIT; 0 otherwise.
- Frame evaluation (4-bit match counter, saturates at STABLE_FRAMES):
  - Either half illegal: pulse `pattern_err`, clear counter to 0, do not update the last-frame register.
  - Legal and equal to the last frame: counter increments, saturating.
  - Legal and different, or first frame after SYNC: counter = 1; store the frame as last frame.
  - Counter reaching STABLE_FRAMES on this evaluation (transition, not saturated hold): load `ten_count`/`unit_count` from the frame and pulse `valid`.
- Published outputs hold through errors, loss of lock and IDLE. Only reset clears them.
- `enable` falling: synchronous move to IDLE next edge; counter and last frame cleared; no pulses.

## Timing
- Reset values: `ten_count`=0, `unit_count`=0, `valid`=0, `locked`=0, `pattern_err`=0, `sync_err`=0, state IDLE, `prev_digit`=0, counter=0.
- Inputs are sampled directly at each rising edge with no synchroniser; they come from the same domain.
- Latency: `valid`, `pattern_err` and new output values appear one edge after the edge sampling the units half. `sync_err` appears one edge after the offending sample.
- `locked` rises the edge after the first tens capture.
- Clean driver, STABLE_FRAMES=2, enable asserted at E0: first `valid` no later than edge E0+6.
- Simultaneous events:
  - illegal pattern and digit stall on the same sample: `sync_err` only;
  - `enable` low wins over all evaluation.
- Reset asserted mid-frame: all state and outputs clear immediately (asynchronous). After release, operation restarts from IDLE.

## Test plan
- Clean driver showing 4,2 with invert=0, STABLE_FRAMES=2 → exactly one `valid` pulse with ten_count=4, unit_count=2 on the second frame; `locked`=1 throughout; no further `valid` while the value stays 42.
- invert=1, bus driven with ~patterns for 9,0 → `valid` with ten_count=9, unit_count=0; no `pattern_err`.
- After 42 is published, units shows 1010101 for one frame, then 42 resumes → `pattern_err` pulses once; outputs stay 42; `valid` re-pulses two frames later.
- 42 published, one frame of 43, then 42 → no `valid` for 43; 42 is republished two frames after it resumes.
- `digit` held at 1 for two consecutive samples while locked → `sync_err` pulse, `locked`=0, outputs held; relock and `valid` within three frames of alternation resuming.
- Blank tens (0000000) with units 7 → `valid` with ten_count=4'hF, unit_count=7. `reset_n` pulsed low mid-frame → all outputs 0 immediately and `locked`=0.
